// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Sequences the shared multiply/divide unit for the multicycle core. A one-cycle
// request from main control starts either the mult or the div unit. The
// sequencer then waits for that unit's stop handshake and loads HI/LO through
// the high/low source muxes. Completion and exceptions are reported back to
// main control, which stalls while busy is high.
//
// Optional feature macro: MULDIV_TIMEOUT_EN
//   defined   : WAIT gives up after TIMEOUT cycles with a timeout_exc pulse
//   undefined : WAIT is unbounded and timeout_exc is tied low
//
// Parameters
//   TIMEOUT  max WAIT cycles before the timeout exception (MULDIV_TIMEOUT_EN)
//   CNT_W    cycle counter width, 2**CNT_W must exceed TIMEOUT
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   op_valid      one-cycle request strobe from main control
//   op_sel        0 = mult, 1 = div (sampled with op_valid)
//   divisor_zero  B register is zero (sampled with op_valid)
//   abort         exception flush; cancels an op that is still waiting
//   mult_stop     mult unit done
//   div_stop      div unit done
//   div_zero      div unit divide-by-zero flag
//   mult_init     one-cycle mult start pulse
//   div_init      one-cycle div start pulse
//   hilo_sel      HI/LO source-mux select: 0 = mult, 1 = div
//   high_load     HI register load enable
//   low_load      LO register load enable
//   busy          high whenever the sequencer is not idle
//   done          one-cycle completion pulse (HI/LO written)
//   div_zero_exc  one-cycle divide-by-zero exception pulse
//   timeout_exc   one-cycle timeout exception pulse
//   cycles        WAIT-cycle count of the current/last op (debug)
//
// Handshake: op_valid is a single-cycle strobe honoured only in IDLE; there is
// no ready signal, main control holds off new requests while busy is high. The
// unit stop signals are level inputs sampled only in WAIT.
//
// The FSM state is held in the typed signal 'state' so checkers can bind to it.
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   input  logic             op_sel,
   input  logic             divisor_zero,
   input  logic             abort,
   input  logic             mult_stop,
   input  logic             div_stop,
   input  logic             div_zero,
   output logic             mult_init,
   output logic             div_init,
   output logic             hilo_sel,
   output logic             high_load,
   output logic             low_load,
   output logic             busy,
   output logic             done,
   output logic             div_zero_exc,
   output logic             timeout_exc,
   output logic [CNT_W-1:0] cycles
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_ZEXC  = 3'd4,
      S_TOUT  = 3'd5
   } state_t;

   // Elaboration-time guard on the counter sizing.
   if ((TIMEOUT < 1) || ((2 ** CNT_W) <= TIMEOUT)) begin : g_bad_cfg
      $error("muldiv_sequencer: 2**CNT_W must exceed TIMEOUT and TIMEOUT must be >= 1");
   end

   state_t             state;
   state_t             state_nx;
   logic               op_r;
   logic               op_nx;
   logic [CNT_W-1:0]   counter;
   logic [CNT_W-1:0]   counter_nx;
   logic               own_stop;

   // Only the stop of the unit that was started counts; the other is ignored.
   assign own_stop = op_r ? div_stop : mult_stop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         op_r    <= 1'b0;
         counter <= '0;
      end else begin
         state   <= state_nx;
         op_r    <= op_nx;
         counter <= counter_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      op_nx      = op_r;
      counter_nx = counter;
      case (state)
         S_IDLE: begin
            if (op_valid) begin
               op_nx = op_sel;
               // A zero divisor is known up front, so the div unit is never started.
               if (op_sel && divisor_zero) state_nx = S_ZEXC;
               else                        state_nx = S_START;
            end
         end
         S_START: begin
            counter_nx = '0;
            state_nx   = S_WAIT;
         end
         S_WAIT: begin
            // The counter only advances while staying in WAIT, so on exit it
            // holds the count that was visible in the final WAIT cycle.
            if (abort) begin
               state_nx = S_IDLE;
            end else if (op_r && div_zero) begin
               state_nx = S_ZEXC;
            end else if (own_stop) begin
               state_nx = S_WRITE;
`ifdef MULDIV_TIMEOUT_EN
            end else if (counter == CNT_W'(TIMEOUT - 1)) begin
               state_nx = S_TOUT;
`endif
            end else if (counter != '1) begin
               counter_nx = counter + 1'b1;
            end
         end
         S_WRITE: state_nx = S_IDLE;  // committed; abort has no effect here
         S_ZEXC:  state_nx = S_IDLE;
         S_TOUT:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Moore decodes of registered state only.
   assign mult_init    = (state == S_START) && !op_r;
   assign div_init     = (state == S_START) &&  op_r;
   assign hilo_sel     = op_r;
   assign high_load    = (state == S_WRITE);
   assign low_load     = (state == S_WRITE);
   assign done         = (state == S_WRITE);
   assign busy         = (state != S_IDLE);
   assign div_zero_exc = (state == S_ZEXC);
`ifdef MULDIV_TIMEOUT_EN
   assign timeout_exc  = (state == S_TOUT);
`else
   assign timeout_exc  = 1'b0;
`endif
   assign cycles       = counter;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Directed bench for muldiv_sequencer. Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point, so each sample shows the
// state entered on the preceding edge. Pulse totals are accumulated on the
// falling edge and compared as deltas around each scenario.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

   localparam int CNT_W = 7;

   logic             clk;
   logic             reset;
   logic             op_valid;
   logic             op_sel;
   logic             divisor_zero;
   logic             abort;
   logic             mult_stop;
   logic             div_stop;
   logic             div_zero;
   logic             mult_init;
   logic             div_init;
   logic             hilo_sel;
   logic             high_load;
   logic             low_load;
   logic             busy;
   logic             done;
   logic             div_zero_exc;
   logic             timeout_exc;
   logic [CNT_W-1:0] cycles;

   int n_cmp = 0;
   int n_bad = 0;

   int n_mult_init = 0;
   int n_div_init  = 0;
   int n_load      = 0;
   int n_done      = 0;
   int n_zexc      = 0;
   int n_tout      = 0;

   int s_mult_init, s_div_init, s_load, s_done, s_zexc, s_tout;

   muldiv_sequencer #(.TIMEOUT(64), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .op_valid     (op_valid),
      .op_sel       (op_sel),
      .divisor_zero (divisor_zero),
      .abort        (abort),
      .mult_stop    (mult_stop),
      .div_stop     (div_stop),
      .div_zero     (div_zero),
      .mult_init    (mult_init),
      .div_init     (div_init),
      .hilo_sel     (hilo_sel),
      .high_load    (high_load),
      .low_load     (low_load),
      .busy         (busy),
      .done         (done),
      .div_zero_exc (div_zero_exc),
      .timeout_exc  (timeout_exc),
      .cycles       (cycles)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- pulse monitors ----------------
   always @(negedge clk) begin
      if (mult_init)    n_mult_init++;
      if (div_init)     n_div_init++;
      if (high_load)    n_load++;
      if (done)         n_done++;
      if (div_zero_exc) n_zexc++;
      if (timeout_exc)  n_tout++;
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic snap();
      s_mult_init = n_mult_init;
      s_div_init  = n_div_init;
      s_load      = n_load;
      s_done      = n_done;
      s_zexc      = n_zexc;
      s_tout      = n_tout;
   endtask

   task automatic idle_inputs();
      op_valid     = 1'b0;
      op_sel       = 1'b0;
      divisor_zero = 1'b0;
      abort        = 1'b0;
      mult_stop    = 1'b0;
      div_stop     = 1'b0;
      div_zero     = 1'b0;
   endtask

   // Issue a request in the current (IDLE) cycle and advance into the next state.
   task automatic issue(input logic sel, input logic dz);
      op_valid     = 1'b1;
      op_sel       = sel;
      divisor_zero = dz;
      tick();
      op_valid     = 1'b0;
      divisor_zero = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle_inputs();
      reset = 1'b0;
      #2;
      check("rst busy",      32'(busy), 32'd0);
      check("rst cycles",    32'(cycles), 32'd0);
      check("rst hilo_sel",  32'(hilo_sel), 32'd0);
      check("rst outs",      32'({mult_init, div_init, high_load, low_load, done,
                                  div_zero_exc, timeout_exc}), 32'd0);
      tick();
      reset = 1'b1;
      tick();

      // ---- mult: stop 33 cycles after mult_init -> cycles = 32 ----
      snap();
      issue(1'b0, 1'b0);
      check("mult start init", 32'(mult_init), 32'd1);
      check("mult start div_init", 32'(div_init), 32'd0);
      check("mult start busy", 32'(busy), 32'd1);
      tick();                        // WAIT cycle 1
      check("mult wait1 init", 32'(mult_init), 32'd0);
      check("mult wait1 cycles", 32'(cycles), 32'd0);
      ticks(32);                     // WAIT cycle 33
      mult_stop = 1'b1;
      check("mult wait33 cycles", 32'(cycles), 32'd32);
      check("mult wait33 no load", 32'(high_load), 32'd0);
      tick();                        // WRITE
      mult_stop = 1'b0;
      check("mult write loads", 32'({high_load, low_load}), 32'd3);
      check("mult write done", 32'(done), 32'd1);
      check("mult write hilo_sel", 32'(hilo_sel), 32'd0);
      check("mult write cycles", 32'(cycles), 32'd32);
      tick();                        // IDLE
      check("mult idle busy", 32'(busy), 32'd0);
      check("mult idle done", 32'(done), 32'd0);
      check("mult idle cycles hold", 32'(cycles), 32'd32);
      check("mult init count", 32'(n_mult_init - s_mult_init), 32'd1);
      check("mult load count", 32'(n_load - s_load), 32'd1);

      // ---- div: mult_stop during WAIT ignored, div_stop at counter 10 ----
      snap();
      issue(1'b1, 1'b0);
      check("div start init", 32'(div_init), 32'd1);
      check("div start mult_init", 32'(mult_init), 32'd0);
      ticks(3);                      // WAIT cycle 3
      mult_stop = 1'b1;
      tick();                        // WAIT cycle 4
      mult_stop = 1'b0;
      check("div foreign stop busy", 32'(busy), 32'd1);
      check("div foreign stop no load", 32'(high_load), 32'd0);
      ticks(7);                      // WAIT cycle 11
      check("div wait11 cycles", 32'(cycles), 32'd10);
      div_stop = 1'b1;
      tick();                        // WRITE
      div_stop = 1'b0;
      check("div write loads", 32'({high_load, low_load}), 32'd3);
      check("div write done", 32'(done), 32'd1);
      check("div write hilo_sel", 32'(hilo_sel), 32'd1);
      tick();
      check("div idle busy", 32'(busy), 32'd0);
      check("div idle hilo_sel hold", 32'(hilo_sel), 32'd1);
      check("div load count", 32'(n_load - s_load), 32'd1);
      check("div mult_init count", 32'(n_mult_init - s_mult_init), 32'd0);

      // ---- zero divisor known at request ----
      snap();
      issue(1'b1, 1'b1);
      check("zdiv exc", 32'(div_zero_exc), 32'd1);
      check("zdiv busy", 32'(busy), 32'd1);
      check("zdiv no load", 32'({high_load, low_load, done}), 32'd0);
      tick();
      check("zdiv idle busy", 32'(busy), 32'd0);
      check("zdiv idle exc", 32'(div_zero_exc), 32'd0);
      check("zdiv div_init count", 32'(n_div_init - s_div_init), 32'd0);
      check("zdiv exc count", 32'(n_zexc - s_zexc), 32'd1);

      // ---- div_zero and div_stop together in WAIT -> ZEXC ----
      snap();
      issue(1'b1, 1'b0);
      ticks(2);                      // WAIT cycle 2
      div_zero = 1'b1;
      div_stop = 1'b1;
      tick();
      div_zero = 1'b0;
      div_stop = 1'b0;
      check("dz+stop exc", 32'(div_zero_exc), 32'd1);
      check("dz+stop no load", 32'({high_load, low_load, done}), 32'd0);
      tick();
      check("dz+stop idle", 32'(busy), 32'd0);
      check("dz+stop load count", 32'(n_load - s_load), 32'd0);

      // ---- abort at WAIT cycle 5 beats a simultaneous mult_stop ----
      snap();
      issue(1'b0, 1'b0);
      ticks(5);                      // WAIT cycle 5
      check("abort wait5 cycles", 32'(cycles), 32'd4);
      abort     = 1'b1;
      mult_stop = 1'b1;
      tick();                        // IDLE
      abort     = 1'b0;
      mult_stop = 1'b0;
      check("abort idle busy", 32'(busy), 32'd0);
      check("abort no write", 32'({high_load, low_load, done}), 32'd0);
      issue(1'b0, 1'b0);             // accepted right after the abort
      check("abort reissue init", 32'(mult_init), 32'd1);
      tick();                        // WAIT cycle 1
      mult_stop = 1'b1;
      tick();
      mult_stop = 1'b0;
      check("abort reissue done", 32'(done), 32'd1);
      check("abort reissue cycles", 32'(cycles), 32'd0);
      tick();
      check("abort done count", 32'(n_done - s_done), 32'd1);

      // ---- asynchronous reset mid-WAIT ----
      snap();
      issue(1'b1, 1'b0);
      ticks(4);                      // WAIT cycle 4, cycles = 3, hilo_sel = 1
      #2;
      reset = 1'b0;
      #1;
      check("async rst busy", 32'(busy), 32'd0);
      check("async rst cycles", 32'(cycles), 32'd0);
      check("async rst hilo_sel", 32'(hilo_sel), 32'd0);
      tick();
      reset = 1'b1;
      tick();
      issue(1'b0, 1'b0);
      check("post rst init", 32'(mult_init), 32'd1);
      tick();
      mult_stop = 1'b1;
      tick();
      mult_stop = 1'b0;
      check("post rst done", 32'(done), 32'd1);
      tick();
      check("post rst load count", 32'(n_load - s_load), 32'd1);

      // ---- timeout / saturation ----
      snap();
      issue(1'b0, 1'b0);
      tick();                        // WAIT cycle 1
`ifdef MULDIV_TIMEOUT_EN
      ticks(63);                     // WAIT cycle 64, counter 63
      check("tout wait cycles", 32'(cycles), 32'd63);
      check("tout wait exc", 32'(timeout_exc), 32'd0);
      tick();
      check("tout exc", 32'(timeout_exc), 32'd1);
      check("tout no load", 32'({high_load, low_load, done}), 32'd0);
      tick();
      check("tout idle busy", 32'(busy), 32'd0);
      check("tout exc count", 32'(n_tout - s_tout), 32'd1);
`else
      ticks(200);
      check("unbounded busy", 32'(busy), 32'd1);
      check("unbounded cycles sat", 32'(cycles), 32'd127);
      check("unbounded tout count", 32'(n_tout - s_tout), 32'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("unbounded abort idle", 32'(busy), 32'd0);
      check("unbounded load count", 32'(n_load - s_load), 32'd0);
`endif

      ticks(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Sequences the shared multiply/divide resource for the multicycle core. Accepts one-cycle op requests from the main control unit and pulses the mult or div start. Waits for the unit's stop handshake, then loads HI/LO through the high/low source muxes. Reports completion or exceptions back to main control, which stalls on busy.

Parameters:
TIMEOUT, 64, max WAIT cycles before timeout exception (used only with MULDIV_TIMEOUT_EN)
CNT_W, 7, cycle counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
op_valid  in  1  one-cycle request strobe from main control
op_sel  in  1  0 = mult, 1 = div; sampled with op_valid
divisor_zero  in  1  B register == 0; sampled with op_valid
abort  in  1  exception flush from main control; cancels in-flight op
mult_stop  in  1  mult unit done
div_stop  in  1  div unit done
div_zero  in  1  div unit divide-by-zero flag
mult_init  out  1  one-cycle mult start pulse
div_init  out  1  one-cycle div start pulse
hilo_sel  out  1  drives HI and LO source-mux selectors: 0 = mult outputs, 1 = div outputs
high_load  out  1  HI register load enable
low_load  out  1  LO register load enable
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse (HI/LO written)
div_zero_exc  out  1  one-cycle divide-by-zero exception pulse
timeout_exc  out  1  one-cycle timeout exception pulse
cycles  out  CNT_W  WAIT-cycle count of the current/last op (debug)

Behaviour:
- Reset (reset=0, async): state=IDLE, op_r=0, counter=0; every output 0, including hilo_sel and cycles. Reset mid-op abandons the op with no HI/LO write.
- States: IDLE, START, WAIT, WRITE, ZEXC, TOUT.
- IDLE:
  - op_valid=1 latches op_r=op_sel.
  - If op_sel=1 and divisor_zero=1 -> ZEXC. Otherwise -> START.
  - op_valid while busy is ignored; main control must not issue it.
- START (1 cycle): mult_init=!op_r, div_init=op_r; counter cleared to 0; -> WAIT.
- WAIT:
  - Counter increments by 1 per cycle and saturates at all-ones.
  - Exit priority, highest first:
    1. abort -> IDLE, no write, no pulse.
    2. op_r=1 and div_zero -> ZEXC.
    3. Own stop (mult_stop if op_r=0, div_stop if op_r=1) -> WRITE. The other unit's stop is ignored.
    4. Timeout condition (feature only) -> TOUT.
- WRITE (1 cycle): high_load=low_load=1, done=1; -> IDLE. abort is ignored here because the write is committed.
- ZEXC (1 cycle): div_zero_exc=1, no loads; -> IDLE.
- TOUT (1 cycle): timeout_exc=1, no loads; -> IDLE.
- hilo_sel = op_r at all times; it holds after the op until the next request.
- cycles = counter. It holds its value in IDLE until the next START.
- All outputs are registered-state decodes (Moore); no output depends combinationally on inputs.
- Latency from the op_valid edge: START at +1, WAIT from +2. A stop seen at WAIT cycle k gives WRITE at +2+k and done at that cycle. The next op_valid is accepted at +3+k.

Optional Feature:
MULDIV_TIMEOUT_EN
- Defined: in WAIT, when counter == TIMEOUT-1 with no stop, no abort and no div_zero, go to TOUT next cycle (timeout_exc pulse, no HI/LO write).
- Undefined: WAIT is unbounded, TOUT is unreachable, and timeout_exc is tied 0. The counter and cycles output remain.

Test Plan:
- Mult: op_valid, op_sel=0; mult_stop 33 cycles after mult_init -> mult_init exactly 1 cycle; one cycle of high_load=low_load=1 with hilo_sel=0 and done=1; cycles=32; busy drops the cycle after.
- Div: op_sel=1, divisor_zero=0; div_stop after 10 WAIT cycles -> div_init pulse; WRITE with hilo_sel=1; mult_stop pulsed during WAIT has no effect.
- Zero divisor: op_sel=1, divisor_zero=1 -> no div_init; div_zero_exc pulse 1 cycle after op_valid; no load; busy high exactly 1 cycle. Also div_zero and div_stop together in WAIT -> ZEXC, no load.
- Abort: abort at WAIT cycle 5 with mult_stop also high -> IDLE, no high_load/low_load/done. A new op_valid the next cycle is accepted.
- Reset: drive reset low asynchronously mid-WAIT -> all outputs 0 immediately. After release, an op_valid the next cycle starts normally.
- Timeout (MULDIV_TIMEOUT_EN, TIMEOUT=64): never assert stop -> timeout_exc 1 cycle after counter reaches 63; no load. Without the macro, busy stays high for 200 cycles and cycles saturates at 127.
